// File: rtl/uart_prog_loader.sv
// UART boot-programming receiver: deserialises 8N1 bytes, packs them MSB-byte-first
// into 32-bit words and writes them to consecutive instruction-memory addresses.
module uart_prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned MAX_WORDS    = 16384,
    parameter logic [31:0] TERM_WORD    = 32'h00000FFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              rx_i,
    output logic              ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              done_o,
    output logic              frame_err_o,
    output logic              overflow_o
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(MAX_WORDS);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [1:0] {LD_WAIT, LD_LOAD, LD_DONE} ld_state_t;

    rx_state_t        rx_state, rx_next;
    ld_state_t        ld_state, ld_next;
    logic             rx_meta, rx_sync;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             half_tick, bit_tick;
    logic [1:0]       byte_idx;
    logic [31:0]      word_q;
    logic [31:0]      full_word;
    logic [ADDR_W:0]  addr_cnt;
    logic             word_done;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

    assign half_tick = (clk_cnt == CNT_W'(HALF_BIT - 1));
    assign bit_tick  = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_next = RX_START;
            RX_START: if (half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_cnt == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (bit_tick) rx_next = rx_sync ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (rx_sync) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            rx_byte     <= '0;
            byte_valid  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_err_o <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                end
                RX_START: clk_cnt <= half_tick ? '0 : clk_cnt + 1'b1;
                RX_DATA: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        rx_byte <= {rx_sync, rx_byte[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        if (rx_sync) byte_valid  <= 1'b1;
                        else         frame_err_o <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: clk_cnt <= '0;
            endcase
        end
    end

    // The fourth byte is folded in combinationally so the write lands one cycle after it.
    assign full_word = {word_q[23:0], rx_byte};
    assign word_done = (ld_state == LD_LOAD) && en_i && byte_valid && (byte_idx == 2'd3);
    assign ready_o   = (ld_state == LD_LOAD);

    always_ff @(posedge clk_i) begin
        if (rst_i) ld_state <= LD_WAIT;
        else       ld_state <= ld_next;
    end

    always_comb begin
        ld_next = ld_state;
        case (ld_state)
            LD_WAIT: if (en_i) ld_next = LD_LOAD;
            LD_LOAD: begin
                if (!en_i)                                ld_next = LD_WAIT;
                else if (word_done && full_word == TERM_WORD) ld_next = LD_DONE;
            end
            LD_DONE: if (!en_i) ld_next = LD_WAIT;
            default: ld_next = LD_WAIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_idx    <= '0;
            word_q      <= '0;
            addr_cnt    <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            done_o      <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            mem_we_o <= 1'b0;
            if (ld_state != LD_WAIT && !en_i) begin
                byte_idx   <= '0;
                addr_cnt   <= '0;
                done_o     <= 1'b0;
                overflow_o <= 1'b0;
            end else if (ld_state == LD_LOAD && byte_valid) begin
                word_q   <= full_word;
                byte_idx <= byte_idx + 1'b1;
                if (word_done) begin
                    if (full_word == TERM_WORD) begin
                        done_o <= 1'b1;
                    end else if (addr_cnt < ADDR_LIMIT) begin
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= addr_cnt[ADDR_W-1:0];
                        mem_wdata_o <= full_word;
                        addr_cnt    <= addr_cnt + 1'b1;
                    end else begin
                        overflow_o <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
